// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-priority
// arbitration, optional packet lock and a registered output stage.
module stream_mux_rr #(
   parameter int WIDTH    = 32,
   parameter int N_CH     = 4,
   parameter int SEL_W    = $clog2(N_CH),
   parameter int RR_MODE  = 1,
   parameter int PKT_MODE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [N_CH-1:0]       i_valid,
   input  logic [N_CH*WIDTH-1:0] i_data,
   input  logic [N_CH-1:0]       i_last,
   output logic [N_CH-1:0]       o_ready,
   output logic                  o_valid,
   output logic [WIDTH-1:0]      o_data,
   output logic                  o_last,
   output logic [SEL_W-1:0]      o_ch,
   input  logic                  i_ready
);

   localparam logic [SEL_W:0]   LP_NCH    = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LP_LASTCH = SEL_W'(N_CH-1);

   logic [SEL_W-1:0] r_ptr;
   logic             r_lock;
   logic [SEL_W-1:0] r_lockCh;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             r_last;
   logic [SEL_W-1:0] r_ch;

   logic             w_loadEn;
   logic [N_CH-1:0]  w_lockMask;
   logic [N_CH-1:0]  w_mask;
   logic [SEL_W-1:0] w_start;
   logic [SEL_W:0]   w_idx;
   logic             w_found;
   logic [SEL_W-1:0] w_grant;
   logic             w_accept;
   logic [SEL_W-1:0] w_nextPtr;
   logic [WIDTH-1:0] w_selData;
   logic             w_selLast;

   assign w_loadEn = !r_valid || i_ready;

   // While a packet is in progress only the locked channel is eligible, even if it is idle.
   always_comb begin
      w_lockMask = '1;
      if (r_lock) begin
         w_lockMask           = '0;
         w_lockMask[r_lockCh] = 1'b1;
      end
      w_mask  = i_valid & w_lockMask;
      w_start = (RR_MODE != 0) ? r_ptr : '0;
      w_idx   = '0;
      w_found = 1'b0;
      w_grant = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_idx = {1'b0, w_start} + (SEL_W+1)'(i);
         if (w_idx >= LP_NCH) begin
            w_idx = w_idx - LP_NCH;
         end
         if (!w_found && w_mask[w_idx[SEL_W-1:0]]) begin
            w_found = 1'b1;
            w_grant = w_idx[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      w_accept = w_found && w_loadEn && i_rst_n;
      o_ready  = '0;
      if (w_accept) begin
         o_ready[w_grant] = 1'b1;
      end
   end

   assign w_nextPtr = (w_grant == LP_LASTCH) ? '0 : w_grant + SEL_W'(1);
   assign w_selData = i_data[w_grant*WIDTH +: WIDTH];
   assign w_selLast = (PKT_MODE != 0) ? i_last[w_grant] : 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr    <= '0;
         r_lock   <= 1'b0;
         r_lockCh <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_last   <= 1'b0;
         r_ch     <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_data  <= w_selData;
         r_last  <= w_selLast;
         r_ch    <= w_grant;
         if (RR_MODE != 0) begin
            r_ptr <= w_nextPtr;
         end
         if (PKT_MODE != 0) begin
            r_lock   <= !i_last[w_grant];
            r_lockCh <= w_grant;
         end
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_ch    = r_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: round-robin, fixed-priority and packet-lock
// instances share one stimulus bus; each scenario checks the relevant instance.
module tb_stream_mux_rr;

   logic        clk;
   logic        rstN;
   logic [3:0]  valid;
   logic [3:0]  last;
   logic        ready;
   logic [31:0] tbData [4];
   logic [127:0] dataBus;

   logic [3:0]  rrReady, fpReady, pkReady;
   logic        rrValid, fpValid, pkValid;
   logic [31:0] rrData, fpData, pkData;
   logic        rrLast, fpLast, pkLast;
   logic [1:0]  rrCh, fpCh, pkCh;

   int numCompared;
   int numMismatched;

   assign dataBus = {tbData[3], tbData[2], tbData[1], tbData[0]};

   stream_mux_rr #(.WIDTH(32), .N_CH(4), .RR_MODE(1), .PKT_MODE(0)) dutRr (
      .i_clk(clk), .i_rst_n(rstN), .i_valid(valid), .i_data(dataBus), .i_last(last),
      .o_ready(rrReady), .o_valid(rrValid), .o_data(rrData), .o_last(rrLast),
      .o_ch(rrCh), .i_ready(ready));

   stream_mux_rr #(.WIDTH(32), .N_CH(4), .RR_MODE(0), .PKT_MODE(0)) dutFp (
      .i_clk(clk), .i_rst_n(rstN), .i_valid(valid), .i_data(dataBus), .i_last(last),
      .o_ready(fpReady), .o_valid(fpValid), .o_data(fpData), .o_last(fpLast),
      .o_ch(fpCh), .i_ready(ready));

   stream_mux_rr #(.WIDTH(32), .N_CH(4), .RR_MODE(1), .PKT_MODE(1)) dutPkt (
      .i_clk(clk), .i_rst_n(rstN), .i_valid(valid), .i_data(dataBus), .i_last(last),
      .o_ready(pkReady), .o_valid(pkValid), .o_data(pkData), .o_last(pkLast),
      .o_ch(pkCh), .i_ready(ready));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wordOf(input int ch, input int beat);
      return 32'hD000_0000 | 32'(ch << 8) | 32'(beat);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic r);
      valid = v;
      last  = l;
      ready = r;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input logic [3:0] v, input logic [3:0] l);
      rstN = 1'b0;
      applyStimulus(v, l, 1'b1);
      tick;
      tick;
      rstN = 1'b1;
      #1;
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      rstN = 1'b0;
      for (int k = 0; k < 4; k++) tbData[k] = wordOf(k, 0);
      applyStimulus(4'hF, 4'h0, 1'b1);
      tick;
      tick;
      checkOutput("rstReady", 32'(rrReady), 32'h0);
      checkOutput("rstValid", 32'(rrValid), 32'h0);
      checkOutput("rstCh", 32'(rrCh), 32'h0);
      checkOutput("rstData", rrData, 32'h0);
      checkOutput("rstPkReady", 32'(pkReady), 32'h0);
      rstN = 1'b1;
      #1;
      checkOutput("firstReady", 32'(rrReady), 32'h1);
      tick;
      checkOutput("firstValid", 32'(rrValid), 32'h1);
      checkOutput("firstCh", 32'(rrCh), 32'h0);
      checkOutput("firstData", rrData, wordOf(0, 0));

      // All channels valid with downstream ready: strict rotation, no bubbles.
      for (int i = 1; i <= 6; i++) begin
         checkOutput("rrReady", 32'(rrReady), 32'(1 << (i % 4)));
         tick;
         checkOutput("rrValid", 32'(rrValid), 32'h1);
         checkOutput("rrCh", 32'(rrCh), 32'(i % 4));
         checkOutput("rrData", rrData, wordOf(i % 4, 0));
      end

      applyStimulus(4'hF, 4'h0, 1'b0);
      checkOutput("stallReady", 32'(rrReady), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick;
         checkOutput("stallValid", 32'(rrValid), 32'h1);
         checkOutput("stallCh", 32'(rrCh), 32'h2);
         checkOutput("stallData", rrData, wordOf(2, 0));
         checkOutput("stallReady", 32'(rrReady), 32'h0);
      end
      applyStimulus(4'hF, 4'h0, 1'b1);
      checkOutput("resumeReady", 32'(rrReady), 32'h8);
      tick;
      checkOutput("resumeValid", 32'(rrValid), 32'h1);
      checkOutput("resumeCh", 32'(rrCh), 32'h3);

      // Wrap and skip: move the pointer to 3, then only ch1, then ch3+ch0.
      doReset(4'b0100, 4'h0);
      checkOutput("wrapReady2", 32'(rrReady), 32'h4);
      tick;
      checkOutput("wrapCh2", 32'(rrCh), 32'h2);
      applyStimulus(4'b0010, 4'h0, 1'b1);
      checkOutput("skipReady1", 32'(rrReady), 32'h2);
      tick;
      checkOutput("skipCh1", 32'(rrCh), 32'h1);
      applyStimulus(4'b1001, 4'h0, 1'b1);
      checkOutput("wrapReady3", 32'(rrReady), 32'h8);
      tick;
      checkOutput("wrapCh3", 32'(rrCh), 32'h3);
      applyStimulus(4'b0000, 4'h0, 1'b1);
      checkOutput("idleReady", 32'(rrReady), 32'h0);
      tick;
      checkOutput("drainValid", 32'(rrValid), 32'h0);
      checkOutput("drainCh", 32'(rrCh), 32'h3);
      checkOutput("drainData", rrData, wordOf(3, 0));
      applyStimulus(4'b1001, 4'h0, 1'b1);
      checkOutput("ptrHoldReady", 32'(rrReady), 32'h1);
      tick;
      checkOutput("ptrHoldCh", 32'(rrCh), 32'h0);

      // Fixed priority: ch1 starves ch2 until it deasserts.
      doReset(4'b0110, 4'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("fpReady", 32'(fpReady), 32'h2);
         tick;
         checkOutput("fpCh", 32'(fpCh), 32'h1);
      end
      applyStimulus(4'b0100, 4'h0, 1'b1);
      checkOutput("fpReady2", 32'(fpReady), 32'h4);
      tick;
      checkOutput("fpCh2", 32'(fpCh), 32'h2);

      // Packet lock: ch0 sends three beats with a gap while ch1 waits.
      tbData[0] = wordOf(0, 1);
      tbData[1] = wordOf(1, 1);
      doReset(4'b0011, 4'b0000);
      checkOutput("pkReadyB1", 32'(pkReady), 32'h1);
      tick;
      checkOutput("pkChB1", 32'(pkCh), 32'h0);
      checkOutput("pkLastB1", 32'(pkLast), 32'h0);
      checkOutput("pkDataB1", pkData, wordOf(0, 1));
      tbData[0] = wordOf(0, 2);
      applyStimulus(4'b0011, 4'b0010, 1'b1);
      checkOutput("pkReadyB2", 32'(pkReady), 32'h1);
      tick;
      checkOutput("pkLastB2", 32'(pkLast), 32'h0);
      checkOutput("pkDataB2", pkData, wordOf(0, 2));
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      for (int i = 0; i < 2; i++) begin
         checkOutput("pkGapReady", 32'(pkReady), 32'h0);
         tick;
         checkOutput("pkGapValid", 32'(pkValid), 32'h0);
      end
      tbData[0] = wordOf(0, 3);
      applyStimulus(4'b0011, 4'b0011, 1'b1);
      checkOutput("pkReadyB3", 32'(pkReady), 32'h1);
      tick;
      checkOutput("pkChB3", 32'(pkCh), 32'h0);
      checkOutput("pkLastB3", 32'(pkLast), 32'h1);
      checkOutput("pkDataB3", pkData, wordOf(0, 3));
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      checkOutput("pkReadyCh1", 32'(pkReady), 32'h2);
      tick;
      checkOutput("pkChCh1", 32'(pkCh), 32'h1);
      checkOutput("pkLastCh1", 32'(pkLast), 32'h1);

      // Reset mid-packet must clear the lock and drop the output beat.
      applyStimulus(4'b0011, 4'b0000, 1'b1);
      checkOutput("pkRelockReady", 32'(pkReady), 32'h1);
      tick;
      checkOutput("pkRelockLast", 32'(pkLast), 32'h0);
      rstN = 1'b0;
      #1;
      checkOutput("pkRstValid", 32'(pkValid), 32'h0);
      checkOutput("pkRstReady", 32'(pkReady), 32'h0);
      tick;
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      rstN = 1'b1;
      #1;
      checkOutput("pkUnlockReady", 32'(pkReady), 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel valid/ready stream multiplexer; parametrised successor of the 4-way combinational select mux.
- Arbitrates among N_CH input streams (round-robin or fixed priority) and forwards one beat per cycle through a registered output stage.
- Optional packet lock holds the grant until the last beat of a packet.
- Sits between multiple producers (DMA/sensor channels) and a single shared consumer.

Parameters:
- WIDTH, 32, data width per channel
- N_CH, 4, number of input channels (>=2)
- SEL_W, $clog2(N_CH), width of channel index (derived; do not override)
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- PKT_MODE, 0, 1 = grant locked from first beat until beat with last=1; 0 = per-beat arbitration

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  N_CH  per-channel valid
- i_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- i_last  input  N_CH  per-channel end-of-packet flag (ignored when PKT_MODE=0)
- o_ready  output  N_CH  per-channel accept; one-hot or zero
- o_valid  output  1  output beat valid
- o_data  output  WIDTH  output beat data
- o_last  output  1  output end-of-packet flag
- o_ch  output  SEL_W  source channel of current output beat
- i_ready  input  1  downstream accept

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_data=0, o_last=0, o_ch=0, rr pointer=0, lock=0. o_ready=0 while i_rst_n=0.
- Transfer rules: input transfer on channel k when i_valid[k] && o_ready[k]; output transfer when o_valid && i_ready.
- load_en = !o_valid || i_ready. Full throughput: 1 beat/cycle with i_ready held high.
- Grant: combinational from i_valid, pointer and lock.
  - o_ready[g] = load_en && i_valid[g] for the granted g only.
  - o_ready is combinationally dependent on i_valid and i_ready. Documented; no combinational path from i_data.
- Round-robin: search starts at index ptr and wraps modulo N_CH; first valid channel wins. After an accepted beat from g, ptr <= (g+1) mod N_CH (wrap at N_CH-1 -> 0). ptr is unchanged when no beat is accepted.
- Fixed priority: lowest index with i_valid=1 wins; ptr unused.
- Output register: on accept, o_data <= selected data, o_ch <= g, o_last <= i_last[g] (forced 1 when PKT_MODE=0), o_valid <= 1. Latency is one cycle from input accept to o_valid.
- Drain: if o_valid && i_ready and no input is accepted the same cycle, o_valid <= 0. o_data, o_ch and o_last hold their last values.
- Stall: o_valid && !i_ready -> o_ready all 0; o_data, o_ch and o_last stable (AXI-style hold).
- Packet lock (PKT_MODE=1):
  - An accepted beat with i_last=0 sets lock=1 and lock_ch=g.
  - While locked, only lock_ch may be granted. Other channels wait even if lock_ch is idle; no bubble-skipping.
  - An accepted beat with i_last=1 clears lock. ptr advances as normal.
- Simultaneous drain and load in one cycle: output register is replaced with the new beat and o_valid stays 1.
- No valid inputs: no grant, ptr and lock unchanged.
- Reset mid-packet: lock cleared and in-flight output beat dropped. Upstream must restart packets.
- Producer rule: i_valid must not drop and i_data must not change before acceptance. This is not checked, but the block must behave deterministically if it happens (re-arbitrates each cycle when unlocked).

Test Plan:
- Reset/idle: hold i_rst_n=0, drive all i_valid=1 -> o_ready=0, o_valid=0, o_ch=0; release -> first accept on ch0, o_data=ch0 word one cycle later.
- Round-robin fairness: N_CH=4, all valid, i_ready=1 -> o_ch sequence 0,1,2,3,0,1..., one beat/cycle, no bubbles.
- Backpressure: o_valid=1, i_ready=0 for 5 cycles -> o_data/o_ch stable, o_ready=0; i_ready=1 -> next beat accepted the same cycle and o_valid stays 1.
- Wrap and skip: ptr=3, only ch1 valid -> ch1 granted, ptr becomes 2; ch3 and ch0 later valid together -> ch3 wins.
- Fixed priority (RR_MODE=0): ch2 and ch1 valid continuously -> ch1 always wins; ch2 starves until ch1 deasserts.
- Packet lock (PKT_MODE=1): ch0 sends 3 beats (last on 3rd) with a 2-cycle gap, ch1 valid throughout -> ch1 blocked until ch0 last accepted, then ch1 granted; output o_last=0,0,1 for ch0.
